// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: predictor modes, 2-bit
// counter encodings and the saturating counter update.
package bp_pkg;

    localparam int BP_STATIC  = 0;
    localparam int BP_BIMODAL = 1;
    localparam int BP_GSHARE  = 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        unique case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, write on the
// clock edge. Only the valid bits carry reset; tag/target/jump are plain data.
module bp_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX     = 6,
    parameter int TAG_W   = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX-1:0]   rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output logic [XLEN-1:0]  rd_target_o,
    output logic             rd_jump_o,
    input  logic             wr_en_i,
    input  logic [IDX-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [XLEN-1:0]  wr_target_i,
    input  logic             wr_jump_i
);

    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [XLEN-1:0]  target [ENTRIES];
    logic             jump   [ENTRIES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
        end else if (wr_en_i) begin
            valid[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !rst_i) begin
            tag[wr_idx_i]    <= wr_tag_i;
            target[wr_idx_i] <= wr_target_i;
            jump[wr_idx_i]   <= wr_jump_i;
        end
    end

    assign rd_hit_o    = valid[rd_idx_i] && (tag[rd_idx_i] == rd_tag_i);
    assign rd_target_o = target[rd_idx_i];
    assign rd_jump_o   = jump[rd_idx_i];

endmodule

// File: rtl/branch_pred_unit.sv
// Dynamic branch predictor (static / bimodal / gshare) with BTB, queried
// combinationally in IF and trained non-speculatively from EX.
module branch_pred_unit
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int GHR_BITS = 6,
    parameter int MODE     = 2,
    localparam int IDX     = $clog2(ENTRIES)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic [IDX-1:0]  pred_idx_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [IDX-1:0]  upd_idx_i,
    input  logic            upd_is_br_i,
    input  logic            upd_is_jump_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_mispred_i,
    output logic [31:0]     stat_br_o,
    output logic [31:0]     stat_mis_o
);

    localparam int TAG_W = XLEN - IDX - 2;

    ctr_t                pht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [IDX-1:0]      lk_idx;
    logic [IDX-1:0]      ghr_ext;
    logic                btb_hit;
    logic                btb_jump;
    logic [XLEN-1:0]     btb_target;
    logic                use_btb;
    logic                upd_br;
    logic                btb_wr;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^upd_pc_i[1:0];

    assign lk_idx     = if_pc_i[IDX+1:2];
    assign ghr_ext    = IDX'(ghr);
    assign pred_idx_o = (MODE == BP_GSHARE) ? (lk_idx ^ ghr_ext) : lk_idx;

    bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .IDX     (IDX),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (lk_idx),
        .rd_tag_i    (if_pc_i[XLEN-1:IDX+2]),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .rd_jump_o   (btb_jump),
        .wr_en_i     (btb_wr),
        .wr_idx_i    (upd_pc_i[IDX+1:2]),
        .wr_tag_i    (upd_pc_i[XLEN-1:IDX+2]),
        .wr_target_i (upd_target_i),
        .wr_jump_i   (upd_is_jump_i)
    );

    // Static mode never consults the tables.
    assign use_btb       = (MODE != BP_STATIC) && btb_hit;
    assign pred_taken_o  = use_btb && (btb_jump || pht[pred_idx_o][1]);
    assign pred_target_o = use_btb ? btb_target : (if_pc_i + XLEN'(4));

    // A branch that is also flagged as a jump is handled purely as a jump.
    assign upd_br = upd_valid_i && upd_is_br_i && !upd_is_jump_i;
    assign btb_wr = upd_valid_i && (upd_is_br_i || upd_is_jump_i) && upd_taken_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= WNT;
            ghr <= '0;
        end else if (upd_br && (MODE != BP_STATIC)) begin
            pht[upd_idx_i] <= ctr_next(pht[upd_idx_i], upd_taken_i);
            if (MODE == BP_GSHARE) ghr <= (ghr << 1) | GHR_BITS'(upd_taken_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_br_o  <= '0;
            stat_mis_o <= '0;
        end else begin
            if (upd_br) stat_br_o <= stat_br_o + 32'd1;
            if (upd_valid_i && upd_mispred_i) stat_mis_o <= stat_mis_o + 32'd1;
        end
    end

endmodule
